md_ctrl: RTL and testbench
==========================

Name: md_ctrl

Overview:
Multiply/divide sequencer in the E stage of the five-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from E-stage decode.
- Models multi-cycle latency with a busy counter and owns the HI/LO registers.
- Drives the stall request that holds any D-stage HI/LO instruction while an operation is in flight.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)
CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
md_op  in  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
rs_val  in  32  forwarded rs operand (E stage)
rt_val  in  32  forwarded rt operand (E stage)
d_is_md  in  1  D-stage instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
busy  out  1  operation in flight
hi  out  32  HI register
lo  out  32  LO register
md_stall  out  1  stall request to the hazard unit

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state IDLE, cnt=0, busy=0, hi=0, lo=0, pending regs=0, md_stall=0 (with d_is_md=0).
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- start = (md_op in 1..4) and state==IDLE.
- Accept (IDLE, start at edge T):
  - Compute the full result combinationally from rs_val/rt_val.
  - Latch it into pend_hi/pend_lo.
  - Load cnt with MULT_CYCLES (op 1,2) or DIV_CYCLES (op 3,4).
  - Go to RUN.
- Arithmetic:
  - mult: signed 32x32->64; hi=[63:32], lo=[31:0].
  - multu: unsigned 32x32->64; hi=[63:32], lo=[31:0].
  - div: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned; lo=quotient, hi=remainder.
  - div/divu with rt_val=0: the latency still elapses; hi/lo are NOT updated at commit (pend_we=0).
- RUN:
  - cnt decrements each edge.
  - On the edge where cnt==1: commit pend_hi/pend_lo to hi/lo (if pend_we), go to IDLE.
  - Result: busy is high exactly N cycles (T+1..T+N); new hi/lo are visible from cycle T+N+1, the same cycle busy falls.
- mthi/mtlo (md_op 5/6) in IDLE:
  - Write rs_val into hi/lo at the next edge; no busy.
  - hi and lo are updated independently; the other register is untouched.
- Any md_op 1..6 arriving in RUN is ignored; the hazard unit prevents it by stalling.
- md_stall = d_is_md & (busy | start). Combinational; also covers the accept cycle itself.
- hi/lo outputs hold their old values throughout RUN. mfhi/mflo never read them mid-operation because of the stall.
- Reset mid-operation:
  - Immediate return to IDLE.
  - The pending result is discarded.
  - hi/lo are cleared to 0.
- md_op 0/7: no effect.

Test Plan:
- Reset, then mult with rs=0xFFFFFFFF, rt=2 -> busy high 5 cycles; afterward hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu with rs=0xFFFFFFFF, rt=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- div with rs=7, rt=0xFFFFFFFE (-2) -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0x00000001.
- divu with rs=7, rt=2 -> lo=3, hi=1. Then divu with rt=0 -> busy 10 cycles, hi/lo remain 1/3.
- Hold d_is_md=1 during an accept plus a 5-cycle mult -> md_stall high 6 consecutive cycles, low on the first cycle busy=0. A mult issued while busy is ignored.
- mthi with rs=0xDEADBEEF -> hi=0xDEADBEEF next cycle, lo unchanged, busy stays 0. Assert reset in the 3rd busy cycle of a div -> busy=0 and hi=lo=0 immediately; no later commit.

Source files
------------

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, models multi-cycle latency with a
// busy countdown and raises the stall request for D-stage HI/LO instructions.
module md_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_is_md,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_stall
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic             r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;
  logic             r_pend_we;

  logic             w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      w_hi_nxt;
  logic [31:0]      w_lo_nxt;
  logic [31:0]      w_pend_hi_nxt;
  logic [31:0]      w_pend_lo_nxt;
  logic             w_pend_we_nxt;

  logic             w_start;
  logic             w_rt_zero;
  logic [63:0]      w_prod_s;
  logic [63:0]      w_prod_u;
  logic signed [32:0] w_rs_s33;
  logic signed [32:0] w_rt_s33;
  logic [31:0]      w_quo_s;
  logic [31:0]      w_rem_s;
  logic [31:0]      w_rt_nz;
  logic [31:0]      w_quo_u;
  logic [31:0]      w_rem_u;
  logic [31:0]      w_res_hi;
  logic [31:0]      w_res_lo;
  logic             w_res_we;

  assign w_start   = (md_op >= OP_MULT) && (md_op <= OP_DIVU) && (r_state == ST_IDLE);
  assign w_rt_zero = (rt_val == 32'd0);

  assign w_prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // 33-bit signed divide so that 0x80000000 / -1 cannot overflow; a zero divisor is
  // replaced by 1 only to keep the arithmetic defined, its result is never committed.
  assign w_rs_s33 = {rs_val[31], rs_val};
  assign w_rt_s33 = w_rt_zero ? 33'sd1 : {rt_val[31], rt_val};
  assign w_quo_s  = 32'(w_rs_s33 / w_rt_s33);
  assign w_rem_s  = 32'(w_rs_s33 % w_rt_s33);
  assign w_rt_nz  = w_rt_zero ? 32'd1 : rt_val;
  assign w_quo_u  = rs_val / w_rt_nz;
  assign w_rem_u  = rs_val % w_rt_nz;

  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    w_res_we = 1'b1;
    unique case (md_op)
      OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
      OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
      OP_DIV: begin
        w_res_hi = w_rem_s;
        w_res_lo = w_quo_s;
        w_res_we = !w_rt_zero;
      end
      OP_DIVU: begin
        w_res_hi = w_rem_u;
        w_res_lo = w_quo_u;
        w_res_we = !w_rt_zero;
      end
      default: w_res_we = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_pend_hi_nxt = r_pend_hi;
    w_pend_lo_nxt = r_pend_lo;
    w_pend_we_nxt = r_pend_we;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_pend_hi_nxt = w_res_hi;
          w_pend_lo_nxt = w_res_lo;
          w_pend_we_nxt = w_res_we;
          w_cnt_nxt     = (md_op <= OP_MULTU) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          w_state_nxt   = ST_RUN;
        end else if (md_op == OP_MTHI) begin
          w_hi_nxt = rs_val;
        end else if (md_op == OP_MTLO) begin
          w_lo_nxt = rs_val;
        end
      end
      default: begin
        // Any op arriving here is dropped; the hazard unit stalls it upstream.
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
          if (r_pend_we) begin
            w_hi_nxt = r_pend_hi;
            w_lo_nxt = r_pend_lo;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_we <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_pend_hi <= w_pend_hi_nxt;
      r_pend_lo <= w_pend_lo_nxt;
      r_pend_we <= w_pend_we_nxt;
    end
  end

  assign busy     = (r_state == ST_RUN);
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign md_stall = d_is_md & (busy | w_start);

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed scenarios followed by randomized traffic,
// compared each cycle against a latency/arithmetic reference model.
module tb_md_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_is_md;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        md_stall;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining busy cycles, architectural HI/LO, pending result.
  int          m_left = 0;
  logic [31:0] m_hi = 0, m_lo = 0, m_ph = 0, m_pl = 0;
  bit          m_we = 0;
  logic        last_stall;

  md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .rs_val(rs_val), .rt_val(rt_val),
    .d_is_md(d_is_md), .busy(busy), .hi(hi), .lo(lo), .md_stall(md_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void compute(input logic [2:0] op, input logic [31:0] a, b,
                                  output logic [31:0] ph, pl, output bit we);
    longint sp, x, y, q, r;
    longint unsigned up;
    we = 1; ph = 0; pl = 0;
    case (op)
      3'd1: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        ph = sp[63:32]; pl = sp[31:0];
      end
      3'd2: begin
        up = longint'({32'd0, a}) * longint'({32'd0, b});
        ph = up[63:32]; pl = up[31:0];
      end
      3'd3: begin
        if (b == 0) we = 0;
        else begin
          x = longint'($signed(a)); y = longint'($signed(b));
          q = x / y; r = x % y;
          pl = q[31:0]; ph = r[31:0];
        end
      end
      default: begin
        if (b == 0) we = 0;
        else begin pl = a / b; ph = a % b; end
      end
    endcase
  endfunction

  // One clock cycle: drive, check the combinational stall, clock, check registered outputs.
  task automatic cycle(input logic [2:0] op, input logic [31:0] a, b, input logic dm);
    bit start;
    md_op = op; rs_val = a; rt_val = b; d_is_md = dm;
    #1;
    start = (op >= 1 && op <= 4) && m_left == 0;
    last_stall = md_stall;
    check("md_stall", {31'd0, md_stall}, {31'd0, dm && (m_left > 0 || start)});
    @(posedge clk);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_we) begin m_hi = m_ph; m_lo = m_pl; end
    end else if (start) begin
      compute(op, a, b, m_ph, m_pl, m_we);
      m_left = (op <= 2) ? MC : DC;
    end else if (op == 5) m_hi = a;
    else if (op == 6) m_lo = a;
    #1;
    check("busy", {31'd0, busy}, {31'd0, m_left > 0});
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
  endtask

  // Issue an op and idle until busy drops, returning how many cycles busy was seen high.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, b, output int n);
    int guard = 0;
    cycle(op, a, b, 1'b0);
    n = busy ? 1 : 0;
    while (busy && guard < 40) begin
      cycle(3'd0, 32'd0, 32'd0, 1'b0);
      if (busy) n++;
      guard++;
    end
  endtask

  initial begin
    int n;
    logic [31:0] ra, rb;
    reset = 1'b1; md_op = 0; rs_val = 0; rt_val = 0; d_is_md = 0;
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_stall", {31'd0, md_stall}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, n);
    check("mult_lat", n, MC);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFE);

    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, n);
    check("multu_lat", n, MC);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    run_op(3'd3, 32'd7, 32'hFFFF_FFFE, n);
    check("div_lat", n, DC);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'h0000_0001);

    run_op(3'd4, 32'd7, 32'd2, n);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);
    run_op(3'd4, 32'd9, 32'd0, n);
    check("div0_lat", n, DC);
    check("div0_lo", lo, 32'd3);
    check("div0_hi", hi, 32'd1);

    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'd0);

    // Stall window: accept cycle plus five busy cycles, with a mult issued mid-run.
    n = 0;
    cycle(3'd1, 32'd3, 32'd4, 1'b1);
    n += last_stall;
    for (int i = 0; i < MC; i++) begin
      cycle((i == 2) ? 3'd1 : 3'd0, 32'd100, 32'd100, 1'b1);
      n += last_stall;
    end
    cycle(3'd0, 32'd0, 32'd0, 1'b1);
    check("stall_len", n, 6);
    check("stall_drop", {31'd0, last_stall}, 32'd0);
    check("ign_hi", hi, 32'd0);
    check("ign_lo", lo, 32'd12);

    cycle(3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
    check("mthi_hi", hi, 32'hDEAD_BEEF);
    check("mthi_lo", lo, 32'd12);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    cycle(3'd6, 32'h1234_5678, 32'd0, 1'b0);
    check("mtlo_lo", lo, 32'h1234_5678);
    check("mtlo_hi", hi, 32'hDEAD_BEEF);

    // Reset in the third busy cycle of a div must discard the result.
    cycle(3'd3, 32'd100, 32'd7, 1'b0);
    cycle(3'd0, 32'd0, 32'd0, 1'b0);
    cycle(3'd0, 32'd0, 32'd0, 1'b0);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_hi", hi, 32'd0);
    check("mid_rst_lo", lo, 32'd0);
    m_left = 0; m_hi = 0; m_lo = 0; m_we = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < DC + 2; i++) cycle(3'd0, 32'd0, 32'd0, 1'b0);
    check("no_commit_hi", hi, 32'd0);
    check("no_commit_lo", lo, 32'd0);

    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 9);
        2: rb = -$urandom_range(1, 9);
        default: rb = $urandom;
      endcase
      cycle(3'($urandom_range(0, 7)), ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
